// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: operation codes, FSM states
// and a helper that classifies which operations can be repeated by a burst.
package shift_reg_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD  = 3'd0,
    MODE_SHL   = 3'd1,
    MODE_SHR   = 3'd2,
    MODE_ROL   = 3'd3,
    MODE_ROR   = 3'd4,
    MODE_LOAD  = 3'd5,
    MODE_CLEAR = 3'd6,
    MODE_RSVD  = 3'd7
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Only shifts and rotates have a meaningful repeat; anything else bursts for zero steps.
  function automatic logic is_shift(input mode_e m);
    return m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR};
  endfunction

endpackage

// File: rtl/shift_step.sv
// One shift/rotate step of STEP bits; every other mode passes the data through.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  mode_e            mode_i,
  input  logic [STEP-1:0]  serial_i,
  output logic [WIDTH-1:0] next_c_o
);

  always_comb begin
    next_c_o = data_i;
    case (mode_i)
      MODE_SHL: next_c_o = {data_i[WIDTH-STEP-1:0], serial_i};
      MODE_SHR: next_c_o = {serial_i, data_i[WIDTH-1:STEP]};
      MODE_ROL: next_c_o = {data_i[WIDTH-STEP-1:0], data_i[WIDTH-1 -: STEP]};
      MODE_ROR: next_c_o = {data_i[STEP-1:0], data_i[WIDTH-1:STEP]};
      default:  next_c_o = data_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Shift/rotate/load register with single-op and autonomous burst execution;
// busy/done handshake the burst engine.
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1,
  parameter int unsigned CNT_W = $clog2(WIDTH / STEP + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [STEP-1:0]   serial_in,
  input  logic [WIDTH-1:0]  parallel_in,
  input  logic              burst_start,
  input  logic [CNT_W-1:0]  burst_len,
  output logic [WIDTH-1:0]  parallel_out,
  output logic [STEP-1:0]   serial_out_msb,
  output logic [STEP-1:0]   serial_out_lsb,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MAX_STEPS = WIDTH / STEP;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   reg_q, reg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  mode_e              mode_in;
  mode_e              step_mode;
  logic [WIDTH-1:0]   step_val;
  logic [CNT_W-1:0]   len_sat;

  assign mode_in   = mode_e'(mode);
  assign step_mode = (state_q == BURST) ? mode_q : mode_in;
  assign len_sat   = (burst_len > CNT_W'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : burst_len;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data_i   (reg_q),
    .mode_i   (step_mode),
    .serial_i (serial_in),
    .next_c_o (step_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      reg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state: a burst latches its op and length; count 0 or 1 means this is the final cycle.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (burst_start) begin
          state_d = BURST;
          mode_d  = mode_in;
          cnt_d   = is_shift(mode_in) ? len_sat : '0;
        end
      end
      BURST: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register update and handshake flags.
  always_comb begin
    reg_d  = reg_q;
    busy_d = (state_d == BURST);
    done_d = (state_q == BURST) && (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (en && !burst_start) begin
          case (mode_in)
            MODE_LOAD:  reg_d = parallel_in;
            MODE_CLEAR: reg_d = '0;
            default:    reg_d = step_val;
          endcase
        end
      end
      BURST: begin
        if (cnt_q != '0) reg_d = step_val;
      end
      default: reg_d = reg_q;
    endcase
  end

  assign parallel_out   = reg_q;
  assign serial_out_msb = reg_q[WIDTH-1 -: STEP];
  assign serial_out_lsb = reg_q[STEP-1:0];
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised successor to the basic serial-in shift register. Supports configurable width and bits-per-step, left and right shift, rotate, parallel load, clear, and an autonomous burst engine that performs N steps with busy/done handshaking. It sits between serial links and word-wide datapaths, serving as a serializer/deserializer front end.

## Interface
Parameters:
- WIDTH, 8, register width in bits; ≥2.
- STEP, 1, bits moved per shift/rotate step; must divide WIDTH; 1 ≤ STEP < WIDTH.
- CNT_W, $clog2(WIDTH/STEP+1), width of burst_len.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  single-op enable, honoured only in IDLE.
- mode  in  3  operation code (mode_e).
- serial_in  in  STEP  bits shifted in: at the LSB end for SHL, at the MSB end for SHR.
- parallel_in  in  WIDTH  load value for LOAD.
- burst_start  in  1  starts a burst; honoured only in IDLE.
- burst_len  in  CNT_W  number of steps in the burst, 0..WIDTH/STEP.
- parallel_out  out  WIDTH  register contents.
- serial_out_msb  out  STEP  reg[WIDTH-1 -: STEP].
- serial_out_lsb  out  STEP  reg[STEP-1:0].
- busy  out  1  high while in BURST.
- done  out  1  one-cycle pulse at the end of a burst.

## Operation
- Mode codes:
  - HOLD=0.
  - SHL=1: reg ← {reg[WIDTH-STEP-1:0], serial_in}.
  - SHR=2: reg ← {serial_in, reg[WIDTH-1:STEP]}.
  - ROL=3: rotate left by STEP.
  - ROR=4: rotate right by STEP.
  - LOAD=5: reg ← parallel_in.
  - CLEAR=6: reg ← 0.
  - 7: reserved, treated as HOLD.
- The FSM has two states, IDLE and BURST.
- IDLE behaviour:
  - en=1 with burst_start=0: execute mode once on that edge.
  - burst_start=1: latch mode and burst_len, go to BURST, and do not modify the register on that edge. burst_start takes priority over en.
  - A burst whose latched mode is not SHL/SHR/ROL/ROR is zero-length.
- BURST behaviour:
  - Perform one latched step per cycle, sampling serial_in on each step.
  - Decrement the remaining count per step.
  - After the last step, return to IDLE and pulse done.
  - en, mode, burst_start and burst_len are ignored in BURST.
- Zero-length burst: one BURST cycle with no register change, then IDLE and done.
- The outputs are registered state; the serial_out_* outputs are combinational slices of the register.

## Timing
- Reset (asynchronous assert): reg=0, state=IDLE, count=0, busy=0, done=0, parallel_out=0, serial_out_*=0.
- Single op: the result is visible on parallel_out immediately after the sampling edge (1-cycle latency).
- Burst of length N, with burst_start sampled at edge k:
  - busy=1 after edge k.
  - Steps occur at edges k+1..k+N.
  - busy=0 and done=1 after edge k+N; done clears after edge k+N+1.
- Burst of length 0: busy=1 after edge k, done=1 after edge k+1, register unchanged.
- Back-to-back bursts: burst_start may be asserted in the cycle where done=1. It is accepted at that edge.
- Reset asserted mid-burst: the burst is aborted immediately, no done pulse is produced, and all outputs take their reset values.
- burst_len greater than WIDTH/STEP is out of range. The design saturates it to WIDTH/STEP.

## Structure
- Package shift_reg_pkg holds:
  - the mode_e enum (3-bit, codes above);
  - the state_e enum {IDLE, BURST}.
- Sub-module shift_step: a combinational block mapping (reg, mode, serial_in) to the next value. It is shared by the single-op path and the burst path.
- The top level contains the FSM, the counter, the register and output decode.

## Test plan
- WIDTH=8, STEP=1:
  1. LOAD 0xA5, then SHL with serial_in=1 → parallel_out=0x4B.
  2. LOAD 0x81, then ROR → 0xC0; then ROL → 0x81.
  3. LOAD 0xFF, then burst SHR, N=8, serial_in=0. Required response:
     - serial_out_lsb=1 before every step;
     - parallel_out=0x00 after edge k+8;
     - busy high for exactly 8 cycles;
     - done is a one-cycle pulse.
  4. Zero-length and non-shift bursts:
     - burst_len=0 → done 2 cycles after start, register unchanged;
     - burst with mode=LOAD → same result (zero-length).
  5. Reset mid-burst: LOAD 0x3C, start burst SHL N=8, assert rst after 3 steps → all outputs 0, busy=0, no done.
- WIDTH=8, STEP=2:
  6. LOAD 0x01, then SHL with serial_in=2'b11 → 0x07. Then burst ROR N=4 → 0x07, with done after edge k+4.
